// File: rtl/mix_unround.sv
// Iterative inverse of the 8x32-bit add/xor/shift mixing round.
// One word update per clock, 24 updates per round, valid/ready on both sides.
module mix_unround #(
  parameter int unsigned NUM_ROUNDS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         busy
);

  localparam int unsigned W          = 32;
  localparam int unsigned NW         = 8;
  localparam logic [4:0]  LAST_STEP  = 5'd23;
  localparam logic [7:0]  LAST_ROUND = 8'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    step_q;
  logic [7:0]    round_q;
  logic [W-1:0]  o [NW];

  logic          load, adv, last_step, last_round;
  logic [2:0]    idx, i1, i2, i3, i4, i5;
  logic [W-1:0]  new_word;

  // Steps run i = 7..0 inside each phase, so the word index is the inverted low step bits.
  always_comb begin
    idx = ~step_q[2:0];
    i1  = idx + 3'd1;
    i2  = idx + 3'd2;
    i3  = idx + 3'd3;
    i4  = idx + 3'd4;
    i5  = idx + 3'd5;
    case (step_q[4:3])
      2'd0:    new_word = o[idx] + (o[i2] >> 17) - (o[i4] >> 12);
      2'd1:    new_word = o[idx] ^ (o[i3] << 16);
      default: new_word = o[idx] - o[i1] + o[i5];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    adv        = 1'b0;
    last_step  = (step_q == LAST_STEP);
    last_round = (round_q == LAST_ROUND);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        adv = 1'b1;
        if (last_step && last_round) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 5'd0;
      round_q <= 8'd0;
      for (int k = 0; k < NW; k++) o[k] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        step_q  <= 5'd0;
        round_q <= 8'd0;
        for (int k = 0; k < NW; k++) o[k] <= in_data[W*k +: W];
      end else if (adv) begin
        o[idx] <= new_word;
        if (last_step) begin
          step_q  <= 5'd0;
          round_q <= last_round ? 8'd0 : round_q + 8'd1;
        end else begin
          step_q <= step_q + 5'd1;
        end
      end
    end
  end

  // Outputs are decodes of registered state; in_ready is held low during reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    for (int k = 0; k < NW; k++) out_data[W*k +: W] = o[k];
  end

endmodule

// File: tb/tb_mix_unround.sv
// Scoreboard bench for mix_unround: one instance with NUM_ROUNDS=1, one with NUM_ROUNDS=3.
module tb_mix_unround;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv [2];
  logic [255:0] id [2];
  logic         ordy [2];
  logic         ir [2];
  logic         ov [2];
  logic [255:0] od [2];
  logic         bz [2];

  logic         ir_a, ov_a, bz_a, ir_b, ov_b, bz_b;
  logic [255:0] od_a, od_b;

  mix_unround #(.NUM_ROUNDS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir_a), .in_data(id[0]),
    .out_valid(ov_a), .out_ready(ordy[0]), .out_data(od_a), .busy(bz_a));

  mix_unround #(.NUM_ROUNDS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir_b), .in_data(id[1]),
    .out_valid(ov_b), .out_ready(ordy[1]), .out_data(od_b), .busy(bz_b));

  assign ir[0] = ir_a; assign ov[0] = ov_a; assign od[0] = od_a; assign bz[0] = bz_a;
  assign ir[1] = ir_b; assign ov[1] = ov_b; assign od[1] = od_b; assign bz[1] = bz_b;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q [$];

  // Forward mixing round, in-place updates as defined for the mixer.
  function automatic logic [255:0] mix(input logic [255:0] s);
    logic [31:0] o [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) o[i] = s[32*i +: 32];
    for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i+1)%8] - o[(i+5)%8];
    for (int i = 0; i < 8; i++) o[i] = o[i] ^ (o[(i+3)%8] << 16);
    for (int i = 0; i < 8; i++) o[i] = o[i] - (o[(i+2)%8] >> 17) + (o[(i+4)%8] >> 12);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = o[i];
    return r;
  endfunction

  function automatic logic [255:0] vec_base(input logic [31:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [255:0] vec_rand();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one state into dut d; returns one cycle after the handshake edge.
  task automatic send(input int d, input logic [255:0] orig, input logic [255:0] mixed);
    int n;
    iv[d] = 1'b1;
    id[d] = mixed;
    n = 0;
    while (!ir[d] && n < 500) begin
      cycle();
      n++;
    end
    checks++;
    if (!ir[d]) begin
      errors++;
      $display("FAIL send_timeout dut%0d: in_ready never rose", d);
    end
    cycle();
    iv[d] = 1'b0;
    exp_q.push_back(orig);
  endtask

  // Wait for out_valid; reports latency in cycles from the handshake and busy cycle count.
  task automatic wait_out(input int d, output int lat, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (!ov[d] && n < 2000) begin
      if (bz[d]) busy_cnt++;
      cycle();
      n++;
    end
    lat = n + 1;
    checks++;
    if (!ov[d]) begin
      errors++;
      $display("FAIL out_timeout dut%0d: out_valid never rose", d);
    end
  endtask

  // Pop the scoreboard and compare against out_data, then consume the result.
  task automatic collect(input int d, input string name);
    logic [255:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    checks++;
    if (od[d] !== e) begin
      errors++;
      $display("FAIL %s: out_data=%h expected=%h", name, od[d], e);
    end
    ordy[d] = 1'b1;
    cycle();
    ordy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ir[d] !== 1'b0 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: ir=%b ov=%b busy=%b od=%h expected 0 0 0 0",
                 d, ir[d], ov[d], bz[d], od[d]);
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ir[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready dut%0d: in_ready=%b expected 1", d, ir[d]);
      end
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    send(0, '0, '0);
    wait_out(0, lat, bc);
    checks++;
    if (lat != 25) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 25", lat);
    end
    checks++;
    if (bc != 24) begin
      errors++;
      $display("FAIL zero_busy: busy cycles %0d expected 24", bc);
    end
    collect(0, "zero_data");
  endtask

  task automatic test_index();
    int lat, bc;
    logic [255:0] v;
    v = vec_base(32'd0);
    send(0, v, mix(v));
    wait_out(0, lat, bc);
    collect(0, "index_data");
  endtask

  task automatic test_three_rounds();
    int lat, bc;
    logic [255:0] v;
    v = vec_base(32'hDEADBEEF);
    send(1, v, mix(mix(mix(v))));
    wait_out(1, lat, bc);
    checks++;
    if (lat != 73) begin
      errors++;
      $display("FAIL r3_latency: got %0d expected 73", lat);
    end
    collect(1, "r3_data");
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [255:0] v, w, held;
    v = vec_rand();
    w = vec_rand();
    send(0, v, mix(v));
    wait_out(0, lat, bc);
    held = od[0];
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (od[0] !== held || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: od=%h ov=%b ir=%b expected od=%h ov=1 ir=0",
                 k, od[0], ov[0], ir[0], held);
      end
    end
    collect(0, "hold_data");
    checks++;
    if (ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b expected 1", ir[0]);
    end
    send(0, w, mix(w));
    wait_out(0, lat, bc);
    checks++;
    if (lat != 25) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 25", lat);
    end
    collect(0, "b2b_data");
  endtask

  task automatic test_mid_reset();
    int lat, bc, seen;
    logic [255:0] v, w;
    v = vec_rand();
    w = vec_rand();
    send(0, v, mix(v));
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || od[0] !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ir=%b ov=%b busy=%b od=%h expected 0 0 0 0",
               ir[0], ov[0], bz[0], od[0]);
    end
    rst = 1'b0;
    void'(exp_q.pop_back());
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (ov[0]) seen++;
      cycle();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_valid: out_valid seen %0d cycles expected 0", seen);
    end
    send(0, w, mix(w));
    wait_out(0, lat, bc);
    collect(0, "midrst_data");
  endtask

  task automatic test_ignore_busy();
    int n;
    logic [255:0] v;
    v = vec_rand();
    send(0, v, mix(v));
    iv[0] = 1'b1;
    n = 0;
    while (!ov[0] && n < 200) begin
      id[0] = vec_rand();
      cycle();
      n++;
    end
    iv[0] = 1'b0;
    checks++;
    if (!ov[0]) begin
      errors++;
      $display("FAIL ignore_timeout: out_valid never rose");
    end
    collect(0, "ignore_data");
    checks++;
    if (exp_q.size() != 0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_idle: queue=%0d in_ready=%b expected 0 1", exp_q.size(), ir[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      id[d] = '0;
      ordy[d] = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_zero();
    test_index();
    test_three_rounds();
    test_back_to_back();
    test_mid_reset();
    test_ignore_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
